fetch_decode_ctrl: RTL and testbench
====================================

// Module: fetch_decode_ctrl
// PURPOSE
//  Multicycle fetch/decode control FSM; sits directly upstream of datapath and drives its control inputs.
//  Holds the PC and fetches 16-bit words from basic_mem. Latches the instruction register (ir) and
//  sequences reg_write, alu_*_src, reg_write_src, alu_cont and mem_we per instruction class.
// PARAMETERS
//  RESET_PC   16'h0000  PC value loaded on reset
//  MEM_LAT    1         read latency of basic_mem in cycles (legal 1..3); FETCH_WAIT lasts MEM_LAT cycles
// PORTS
//  clk            in   1   system clock, all state on posedge
//  reset          in   1   synchronous, active-high reset
//  mem_rdata      in   16  basic_mem q_a (instruction word during fetch)
//  zero_flag      in   1   Z flag from datapath psr, sampled in EXEC of branches
//  pc             out  16  current PC; presented as memory address when mem_addr_sel=0
//  mem_addr_sel   out  1   0=pc drives addr_a, 1=datapath mem_address drives addr_a
//  mem_we         out  1   basic_mem we_a
//  ir             out  16  latched instruction -> datapath data_from_mem_PC
//  reg_write      out  1   register-file write enable
//  reg_write_src  out  2   0=ALU result, 1=memory data, 2/3 reserved (never driven)
//  alu_A_src      out  1   datapath ALU A select
//  alu_B_src      out  1   1=immediate ir[7:0], 0=register B
//  alu_cont       out  6   ALU op code (encodings in package)
//  state_out      out  4   current state encoding, for hexTo7Seg display
//  halted         out  1   high while in S_HALT
// BEHAVIOUR
//  Format: ir[15:12] op, [11:8] A idx / cond, [7:4] ext op, [3:0] B idx; imm/disp = ir[7:0].
//  Reset: pc=RESET_PC, ir=0, state=S_FETCH; all outputs 0 except state_out=S_FETCH; reset wins over all.
//  States: S_FETCH -> S_FETCH_WAIT (MEM_LAT cycles) -> S_DECODE -> class-dependent:
//   R-type (op 0000): S_EXEC -> S_WB -> S_FETCH. alu_B_src=0, alu_A_src=1, alu_cont={2'b00,ext}.
//   Immediate (op ADDI 0101, MOVI 1101): S_EXEC -> S_WB; alu_B_src=1; MOVI uses alu_cont=6'b111111.
//   STOR (op 0100, ext 0100): S_MEM_ADDR -> S_MEM_WR (mem_addr_sel=1, mem_we=1 one cycle) -> S_FETCH.
//   LOAD (op 0100, ext 0000): S_MEM_ADDR -> S_MEM_RD (mem_addr_sel=1, MEM_LAT cycles) -> S_MEM_WB
//    (reg_write=1, reg_write_src=1) -> S_FETCH.
//   Bcond (op 1100): S_EXEC; cond 0000 EQ takes if Z=1, 0001 NE if Z=0, 1110 always; else not taken.
//   HALT (ir==16'hFFFF): S_HALT, sticky until reset. Undefined op: treated as NOP, back to S_FETCH.
//  ir captured from mem_rdata on the last FETCH_WAIT cycle; stable from S_DECODE until next fetch.
//  PC update, exactly once per instruction: not-taken/non-branch pc<=pc+1 on entry to S_DECODE;
//   taken branch pc<=pc+sext(disp8) in S_EXEC (pc already incremented, so target is relative to pc+1).
//   16-bit wrap: 16'hFFFF+1 -> 16'h0000, no flag.
//  reg_write and mem_we are single-cycle pulses, only in S_WB / S_MEM_WB / S_MEM_WR; never both high.
//  Latency: R/imm 5 cycles, STOR 5, LOAD 5+MEM_LAT, branch 4 (with MEM_LAT=1).
//  Outputs are registered-free Moore decodes of state + ir (glitch-free w.r.t. ir since ir held).
// CONFIGURATION
//  STEP_MODE_EN defined: extra input port step (1 bit, synchronous, high-active); FSM idles in S_FETCH
//   until step is seen rising (internal edge detect), executing exactly one instruction per press;
//   held step does not repeat. Undefined: S_FETCH advances unconditionally every cycle; no step port.
// STRUCTURE
//  Package ctrl_pkg: state localparams (4-bit), opcode/ext constants, ALU_ADD 6'b000101,
//   ALU_PASSB 6'b111111, cond codes, HALT_WORD 16'hFFFF.
//  One sub-module: ctrl_decode (combinational ir -> instruction class + alu_cont); FSM + PC in top.
// TESTING
//  Reset with pc=5 mid-LOAD -> next cycle pc=RESET_PC, state=S_FETCH, reg_write=0, mem_we=0.
//  MOVI r1,3 (16'hD103) then ADD r1,r2 (16'h0152) -> alu_cont 111111 then 000101, one reg_write each, pc=2.
//  STOR at pc=4 -> mem_addr_sel=1 with mem_we=1 for exactly one cycle in S_MEM_WR; pc=5 after.
//  LOAD with MEM_LAT=2 -> S_MEM_RD lasts 2 cycles, reg_write_src=1 with reg_write in S_MEM_WB.
//  BEQ disp=-3 at pc=10, Z=1 -> pc=8; Z=0 -> pc=11; pc=16'hFFFF non-branch -> pc=16'h0000.
//  STEP_MODE_EN: step held high 20 cycles -> exactly one instruction retires; 16'hFFFF -> halted=1, sticky.

Source files
------------

// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared state, opcode and ALU encodings for fetch_decode_ctrl
package ctrl_pkg;

  // 4-bit state encodings, also shown on the hex display via state_out
  typedef enum logic [3:0] {
    S_FETCH      = 4'd0,
    S_FETCH_WAIT = 4'd1,
    S_DECODE     = 4'd2,
    S_EXEC       = 4'd3,
    S_WB         = 4'd4,
    S_MEM_ADDR   = 4'd5,
    S_MEM_WR     = 4'd6,
    S_MEM_RD     = 4'd7,
    S_MEM_WB     = 4'd8,
    S_HALT       = 4'd9
  } state_e;

  typedef enum logic [2:0] {
    CLS_NOP,
    CLS_R,
    CLS_IMM,
    CLS_LOAD,
    CLS_STOR,
    CLS_BR,
    CLS_HALT
  } iclass_e;

  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_MEM   = 4'b0100;
  localparam logic [3:0] OP_ADDI  = 4'b0101;
  localparam logic [3:0] OP_BCOND = 4'b1100;
  localparam logic [3:0] OP_MOVI  = 4'b1101;

  localparam logic [3:0] EXT_LOAD = 4'b0000;
  localparam logic [3:0] EXT_STOR = 4'b0100;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_AL = 4'b1110;

  localparam logic [5:0] ALU_ADD   = 6'b000101;
  localparam logic [5:0] ALU_PASSB = 6'b111111;

  localparam logic [15:0] HALT_WORD = 16'hFFFF;

  // Branch resolution from the cond field and the datapath Z flag
  function automatic logic branch_taken(input logic [3:0] cond, input logic z);
    logic taken;
    case (cond)
      COND_EQ: taken = z;
      COND_NE: taken = ~z;
      COND_AL: taken = 1'b1;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// rtl/ctrl_decode.sv - combinational ir -> instruction class and ALU controls
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [15:0] ir_i,
  output iclass_e     iclass_o,
  output logic [5:0]  alu_cont_o,
  output logic        alu_a_src_o,
  output logic        alu_b_src_o
);

  logic [3:0] op;
  logic [3:0] ext;

  assign op  = ir_i[15:12];
  assign ext = ir_i[7:4];

  // Classify the held instruction; anything unrecognised falls through as a NOP
  always_comb begin
    iclass_o    = CLS_NOP;
    alu_cont_o  = 6'b000000;
    alu_a_src_o = 1'b0;
    alu_b_src_o = 1'b0;
    if (ir_i == HALT_WORD) begin
      iclass_o = CLS_HALT;
    end else begin
      case (op)
        OP_RTYPE: begin
          iclass_o    = CLS_R;
          alu_cont_o  = {2'b00, ext};
          alu_a_src_o = 1'b1;
        end
        OP_ADDI: begin
          iclass_o    = CLS_IMM;
          alu_cont_o  = ALU_ADD;
          alu_a_src_o = 1'b1;
          alu_b_src_o = 1'b1;
        end
        OP_MOVI: begin
          iclass_o    = CLS_IMM;
          alu_cont_o  = ALU_PASSB;
          alu_b_src_o = 1'b1;
        end
        OP_MEM: begin
          if (ext == EXT_LOAD)      iclass_o = CLS_LOAD;
          else if (ext == EXT_STOR) iclass_o = CLS_STOR;
        end
        OP_BCOND: iclass_o = CLS_BR;
        default:  iclass_o = CLS_NOP;
      endcase
    end
  end

endmodule

// File: rtl/fetch_decode_ctrl.sv
// rtl/fetch_decode_ctrl.sv - multicycle fetch/decode FSM and PC; STEP_MODE_EN adds single-step input
module fetch_decode_ctrl
  import ctrl_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          MEM_LAT  = 1
) (
  input  logic        clk,
  input  logic        reset,
`ifdef STEP_MODE_EN
  input  logic        step,
`endif
  input  logic [15:0] mem_rdata,
  input  logic        zero_flag,
  output logic [15:0] pc,
  output logic        mem_addr_sel,
  output logic        mem_we,
  output logic [15:0] ir,
  output logic        reg_write,
  output logic [1:0]  reg_write_src,
  output logic        alu_A_src,
  output logic        alu_B_src,
  output logic [5:0]  alu_cont,
  output logic [3:0]  state_out,
  output logic        halted
);

  localparam logic [1:0] LAT_LAST = 2'(MEM_LAT - 1);

  state_e      state_q;
  logic [15:0] pc_q;
  logic [15:0] ir_q;
  logic [1:0]  wait_cnt_q;

  iclass_e     iclass;
  logic [5:0]  dec_alu_cont;
  logic        dec_a_src;
  logic        dec_b_src;
  logic        wait_done;
  logic        fetch_go;

  ctrl_decode u_decode (
    .ir_i        (ir_q),
    .iclass_o    (iclass),
    .alu_cont_o  (dec_alu_cont),
    .alu_a_src_o (dec_a_src),
    .alu_b_src_o (dec_b_src)
  );

  assign wait_done = (wait_cnt_q == LAT_LAST);

`ifdef STEP_MODE_EN
  logic step_q;

  // Remember last step level so only a rising edge releases S_FETCH
  always_ff @(posedge clk) begin
    if (reset) step_q <= 1'b0;
    else       step_q <= step;
  end

  assign fetch_go = step & ~step_q;
`else
  assign fetch_go = 1'b1;
`endif

  // Main sequencer: state, PC, instruction register and memory wait counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_PC;
      ir_q       <= 16'h0000;
      wait_cnt_q <= 2'd0;
    end else begin
      case (state_q)
        S_FETCH: begin
          wait_cnt_q <= 2'd0;
          if (fetch_go) state_q <= S_FETCH_WAIT;
        end
        S_FETCH_WAIT: begin
          if (wait_done) begin
            ir_q       <= mem_rdata;
            pc_q       <= pc_q + 16'd1;
            wait_cnt_q <= 2'd0;
            state_q    <= S_DECODE;
          end else begin
            wait_cnt_q <= wait_cnt_q + 2'd1;
          end
        end
        S_DECODE: begin
          case (iclass)
            CLS_R, CLS_IMM, CLS_BR: state_q <= S_EXEC;
            CLS_LOAD, CLS_STOR:     state_q <= S_MEM_ADDR;
            CLS_HALT:               state_q <= S_HALT;
            default:                state_q <= S_FETCH;
          endcase
        end
        S_EXEC: begin
          if (iclass == CLS_BR) begin
            // pc already points past the branch, so the target is relative to pc+1
            if (branch_taken(ir_q[11:8], zero_flag))
              pc_q <= pc_q + {{8{ir_q[7]}}, ir_q[7:0]};
            state_q <= S_FETCH;
          end else begin
            state_q <= S_WB;
          end
        end
        S_WB: state_q <= S_FETCH;
        S_MEM_ADDR: begin
          wait_cnt_q <= 2'd0;
          state_q    <= (iclass == CLS_STOR) ? S_MEM_WR : S_MEM_RD;
        end
        S_MEM_WR: state_q <= S_FETCH;
        S_MEM_RD: begin
          if (wait_done) begin
            wait_cnt_q <= 2'd0;
            state_q    <= S_MEM_WB;
          end else begin
            wait_cnt_q <= wait_cnt_q + 2'd1;
          end
        end
        S_MEM_WB: state_q <= S_FETCH;
        S_HALT:   state_q <= S_HALT;
        default:  state_q <= S_FETCH;
      endcase
    end
  end

  // Moore control decode from state and the held ir; write strobes confined to one state each
  always_comb begin
    mem_addr_sel  = 1'b0;
    mem_we        = 1'b0;
    reg_write     = 1'b0;
    reg_write_src = 2'b00;
    alu_A_src     = 1'b0;
    alu_B_src     = 1'b0;
    alu_cont      = 6'b000000;
    case (state_q)
      S_EXEC, S_WB: begin
        alu_A_src = dec_a_src;
        alu_B_src = dec_b_src;
        alu_cont  = dec_alu_cont;
        reg_write = (state_q == S_WB);
      end
      S_MEM_WR: begin
        mem_addr_sel = 1'b1;
        mem_we       = 1'b1;
      end
      S_MEM_RD: mem_addr_sel = 1'b1;
      S_MEM_WB: begin
        mem_addr_sel  = 1'b1;
        reg_write     = 1'b1;
        reg_write_src = 2'b01;
      end
      default: ;
    endcase
  end

  assign pc        = pc_q;
  assign ir        = ir_q;
  assign state_out = state_q;
  assign halted    = (state_q == S_HALT);

endmodule

// File: tb/tb_fetch_decode_ctrl.sv
// tb/tb_fetch_decode_ctrl.sv - directed self-checking bench for fetch_decode_ctrl
module tb_fetch_decode_ctrl;

  localparam logic [3:0] ST_FETCH    = 4'd0;
  localparam logic [3:0] ST_DECODE   = 4'd2;
  localparam logic [3:0] ST_EXEC     = 4'd3;
  localparam logic [3:0] ST_WB       = 4'd4;
  localparam logic [3:0] ST_MEM_ADDR = 4'd5;
  localparam logic [3:0] ST_MEM_WR   = 4'd6;
  localparam logic [3:0] ST_MEM_RD   = 4'd7;
  localparam logic [3:0] ST_MEM_WB   = 4'd8;
  localparam logic [3:0] ST_HALT     = 4'd9;
  localparam logic [15:0] NOP_WORD   = 16'h3000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic zero_flag = 1'b0;
  logic step = 1'b0;

  logic [15:0] mem [0:255];
  logic [15:0] rd1, rd2a, rd2b;

  logic [15:0] pc1, ir1, pc2, ir2;
  logic        sel1, we1, rw1, asrc1, bsrc1, halt1;
  logic        sel2, we2, rw2, asrc2, bsrc2, halt2;
  logic [1:0]  rws1, rws2;
  logic [5:0]  alu1, alu2;
  logic [3:0]  st1, st2;

  int tests = 0;
  int failed = 0;
  int dec_cnt;

  always #5 clk = ~clk;

  fetch_decode_ctrl #(.RESET_PC(16'h0000), .MEM_LAT(1)) u1 (
    .clk(clk), .reset(reset),
`ifdef STEP_MODE_EN
    .step(step),
`endif
    .mem_rdata(rd1), .zero_flag(zero_flag), .pc(pc1), .mem_addr_sel(sel1), .mem_we(we1),
    .ir(ir1), .reg_write(rw1), .reg_write_src(rws1), .alu_A_src(asrc1), .alu_B_src(bsrc1),
    .alu_cont(alu1), .state_out(st1), .halted(halt1)
  );

  fetch_decode_ctrl #(.RESET_PC(16'h0000), .MEM_LAT(2)) u2 (
    .clk(clk), .reset(reset),
`ifdef STEP_MODE_EN
    .step(step),
`endif
    .mem_rdata(rd2b), .zero_flag(zero_flag), .pc(pc2), .mem_addr_sel(sel2), .mem_we(we2),
    .ir(ir2), .reg_write(rw2), .reg_write_src(rws2), .alu_A_src(asrc2), .alu_B_src(bsrc2),
    .alu_cont(alu2), .state_out(st2), .halted(halt2)
  );

  // Instruction memory with one- and two-cycle registered read paths addressed by pc
  always @(posedge clk) begin
    rd1  <= mem[pc1[7:0]];
    rd2a <= mem[pc2[7:0]];
    rd2b <= rd2a;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_state(input bit which, input logic [3:0] st, input int budget, input string tag);
    int n;
    n = 0;
    while (((which ? st2 : st1) !== st) && n < budget) begin
      tick();
      n++;
    end
    tests++;
    assert ((which ? st2 : st1) === st)
    else begin
      failed++;
      $error("FAIL %s: timeout, state %0h expected %0h", tag, (which ? st2 : st1), st);
    end
  endtask

  task automatic fill_nop();
    for (int i = 0; i < 256; i++) mem[i] = NOP_WORD;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    fill_nop();
    tick();
    tick();
    chk("rst_pc1", pc1, 16'h0000);
    chk("rst_state1", st1, ST_FETCH);
    chk("rst_ir1", ir1, 16'h0000);
    chk("rst_rw1", rw1, 1'b0);
    chk("rst_rws1", rws1, 2'b00);
    chk("rst_we1", we1, 1'b0);
    chk("rst_sel1", sel1, 1'b0);
    chk("rst_alu1", alu1, 6'd0);
    chk("rst_halt1", halt1, 1'b0);
    chk("rst_pc2", pc2, 16'h0000);
    chk("rst_state2", st2, ST_FETCH);
    chk("rst_ir2", ir2, 16'h0000);
    chk("rst_ctl2", {sel2, we2, rw2, rws2, asrc2, bsrc2, halt2}, 16'h0000);
    chk("rst_alu2", alu2, 6'd0);

`ifdef STEP_MODE_EN
    mem[1] = 16'hFFFF;
    step = 1'b0;
    do_reset();
    repeat (4) tick();
    chk("step_idle_state", st1, ST_FETCH);
    chk("step_idle_pc", pc1, 16'h0000);
    step = 1'b1;
    dec_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (st1 == ST_DECODE) dec_cnt++;
    end
    chk("step_one_retire", 16'(dec_cnt), 16'd1);
    chk("step_pc", pc1, 16'h0001);
    chk("step_back_fetch", st1, ST_FETCH);
    step = 1'b0;
    tick();
    step = 1'b1;
    wait_state(1'b0, ST_HALT, 10, "step_halt_reach");
    chk("step_halted", halt1, 1'b1);
    step = 1'b0;
    repeat (3) tick();
    step = 1'b1;
    repeat (3) tick();
    chk("step_halt_sticky", halt1, 1'b1);
    chk("step_halt_pc", pc1, 16'h0002);
`else
    // MOVI r1,3 then ADD r1,r2
    mem[0] = 16'hD103;
    mem[1] = 16'h0152;
    reset = 1'b0;
    tick();
    tick();
    chk("movi_ir", ir1, 16'hD103);
    chk("movi_pc", pc1, 16'h0001);
    tick();
    chk("movi_exec_alu", alu1, 6'b111111);
    chk("movi_exec_bsrc", bsrc1, 1'b1);
    chk("movi_exec_rw", rw1, 1'b0);
    tick();
    chk("movi_wb_rw", rw1, 1'b1);
    chk("movi_wb_rws", rws1, 2'b00);
    tick();
    chk("movi_done_rw", rw1, 1'b0);
    tick();
    tick();
    chk("add_ir", ir1, 16'h0152);
    tick();
    chk("add_exec_alu", alu1, 6'b000101);
    chk("add_exec_srcs", {asrc1, bsrc1}, 2'b10);
    tick();
    chk("add_wb_rw", rw1, 1'b1);
    tick();
    chk("add_done_state", st1, ST_FETCH);
    chk("add_done_rw", rw1, 1'b0);
    chk("add_done_pc", pc1, 16'h0002);

    // STOR at pc=4
    fill_nop();
    mem[4] = 16'h4142;
    do_reset();
    wait_state(1'b0, ST_MEM_ADDR, 40, "stor_reach");
    chk("stor_addr_pc", pc1, 16'h0005);
    chk("stor_addr_we", we1, 1'b0);
    tick();
    chk("stor_wr_state", st1, ST_MEM_WR);
    chk("stor_wr_we", we1, 1'b1);
    chk("stor_wr_sel", sel1, 1'b1);
    chk("stor_wr_rw", rw1, 1'b0);
    tick();
    chk("stor_after_state", st1, ST_FETCH);
    chk("stor_after_we", we1, 1'b0);
    chk("stor_after_sel", sel1, 1'b0);
    chk("stor_after_pc", pc1, 16'h0005);

    // LOAD at pc=4 on the two-cycle memory
    fill_nop();
    mem[4] = 16'h4100;
    do_reset();
    wait_state(1'b1, ST_MEM_RD, 60, "load2_reach");
    chk("load2_pc", pc2, 16'h0005);
    chk("load2_rd1_sel", sel2, 1'b1);
    chk("load2_rd1_rw", rw2, 1'b0);
    tick();
    chk("load2_rd2_state", st2, ST_MEM_RD);
    tick();
    chk("load2_wb_state", st2, ST_MEM_WB);
    chk("load2_wb_rw", rw2, 1'b1);
    chk("load2_wb_rws", rws2, 2'b01);
    chk("load2_wb_we", we2, 1'b0);
    tick();
    chk("load2_done_state", st2, ST_FETCH);
    chk("load2_done_rw", rw2, 1'b0);

    // Reset mid-LOAD with pc=5
    do_reset();
    wait_state(1'b0, ST_MEM_RD, 40, "load1_reach");
    chk("load1_pc", pc1, 16'h0005);
    reset = 1'b1;
    tick();
    chk("midrst_pc", pc1, 16'h0000);
    chk("midrst_state", st1, ST_FETCH);
    chk("midrst_rw", rw1, 1'b0);
    chk("midrst_we", we1, 1'b0);

    // BEQ disp=-3 at pc=10
    fill_nop();
    mem[10] = 16'hC0FD;
    zero_flag = 1'b1;
    do_reset();
    wait_state(1'b0, ST_EXEC, 60, "beq_t_reach");
    chk("beq_t_exec_pc", pc1, 16'h000B);
    chk("beq_t_exec_rw", rw1, 1'b0);
    tick();
    chk("beq_t_state", st1, ST_FETCH);
    chk("beq_t_pc", pc1, 16'h0008);
    zero_flag = 1'b0;
    do_reset();
    wait_state(1'b0, ST_EXEC, 60, "beq_nt_reach");
    tick();
    chk("beq_nt_state", st1, ST_FETCH);
    chk("beq_nt_pc", pc1, 16'h000B);

    // Branch-always to 0xFFFF, then the NOP there wraps pc to 0
    fill_nop();
    mem[0] = 16'hCEFE;
    do_reset();
    wait_state(1'b0, ST_EXEC, 10, "bra_reach");
    tick();
    chk("bra_pc", pc1, 16'hFFFF);
    wait_state(1'b0, ST_DECODE, 10, "wrap_reach");
    chk("wrap_pc", pc1, 16'h0000);
    chk("wrap_ir", ir1, NOP_WORD);
    tick();
    chk("nop_back_fetch", st1, ST_FETCH);

    // HALT is sticky until reset
    fill_nop();
    mem[0] = 16'hFFFF;
    do_reset();
    wait_state(1'b0, ST_HALT, 10, "halt_reach");
    chk("halt_flag", halt1, 1'b1);
    repeat (6) tick();
    chk("halt_sticky_state", st1, ST_HALT);
    chk("halt_sticky_pc", pc1, 16'h0001);
    chk("halt_sticky_ctl", {sel1, we1, rw1}, 3'b000);
    reset = 1'b1;
    tick();
    chk("halt_cleared", halt1, 1'b0);
    chk("halt_rst_state", st1, ST_FETCH);
    reset = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
